// File: rtl/pixel_ray_scheduler.sv
// Raster-scan sequencer that emits per-pixel beam positions and 12-bit directional vectors.
// Optional macro PIXEL_RAY_SCHEDULER_STALL_COUNT_EN adds a saturating backpressure stall counter.
module pixel_ray_scheduler #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             frame_abort,
  input  logic [2:0][11:0] camera_location,
  input  logic [2:0][11:0] beginning_pixel_location,
  input  logic [2:0][11:0] pixels_delta_location,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0][10:0] beam_position,
  output logic [2:0][11:0] vector,
  output logic             last_in_row,
  output logic             last_in_frame,
`ifdef PIXEL_RAY_SCHEDULER_STALL_COUNT_EN
  output logic [15:0]      stall_count,
`endif
  output logic             frame_done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [10:0] X_LAST = 11'(H_PIXELS - 1);
  localparam logic [10:0] Y_LAST = 11'(V_PIXELS - 1);

  state_t      state;
  logic [11:0] base0, base2;
  logic [11:0] d0, d1, d2;

  logic [11:0] start0, start1, start2;
  logic [10:0] x_inc, y_inc;
  logic        xfer, start_ok;

  assign start0   = camera_location[0] - beginning_pixel_location[0];
  assign start1   = camera_location[1] - beginning_pixel_location[1];
  assign start2   = camera_location[2] - beginning_pixel_location[2];
  assign x_inc    = beam_position[1] + 11'd1;
  assign y_inc    = beam_position[0] + 11'd1;
  assign xfer     = out_valid && out_ready;
  assign start_ok = (state == IDLE) && frame_start && !frame_abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      frame_done    <= 1'b0;
      last_in_row   <= 1'b0;
      last_in_frame <= 1'b0;
      beam_position <= '0;
      vector        <= '0;
      base0         <= '0;
      base2         <= '0;
      d0            <= '0;
      d1            <= '0;
      d2            <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state         <= RUN;
            busy          <= 1'b1;
            out_valid     <= 1'b1;
            base0         <= start0;
            base2         <= start2;
            d0            <= pixels_delta_location[0];
            d1            <= pixels_delta_location[1];
            d2            <= pixels_delta_location[2];
            beam_position <= '0;
            vector        <= {start2, start1, start0};
            last_in_row   <= (X_LAST == 11'd0);
            last_in_frame <= (X_LAST == 11'd0) && (Y_LAST == 11'd0);
          end
        end
        RUN: begin
          if (frame_abort) begin
            state         <= IDLE;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            last_in_row   <= 1'b0;
            last_in_frame <= 1'b0;
          end else if (xfer) begin
            if (last_in_frame) begin
              state         <= IDLE;
              busy          <= 1'b0;
              out_valid     <= 1'b0;
              frame_done    <= 1'b1;
              last_in_row   <= 1'b0;
              last_in_frame <= 1'b0;
            end else if (last_in_row) begin
              // row wrap: x-dependent components return to their row-start values
              beam_position[1] <= 11'd0;
              beam_position[0] <= y_inc;
              vector[0]        <= base0;
              vector[1]        <= vector[1] - d1;
              vector[2]        <= base2;
              last_in_row      <= (X_LAST == 11'd0);
              last_in_frame    <= (X_LAST == 11'd0) && (y_inc == Y_LAST);
            end else begin
              beam_position[1] <= x_inc;
              vector[0]        <= vector[0] - d0;
              vector[2]        <= vector[2] + d2;
              last_in_row      <= (x_inc == X_LAST);
              last_in_frame    <= (x_inc == X_LAST) && (beam_position[0] == Y_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIXEL_RAY_SCHEDULER_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      stall_count <= '0;
    end else if ((state == RUN) && out_valid && !out_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_ray_scheduler.sv
// Directed bench for pixel_ray_scheduler: a 4x3 instance for the main scans and a 1x1 instance.
module tb_pixel_ray_scheduler;
  localparam int H = 4;
  localparam int V = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, frame_start, frame_abort, out_ready;
  logic [2:0][11:0] camera_location, beginning_pixel_location, pixels_delta_location;
  logic             busy, out_valid, last_in_row, last_in_frame, frame_done;
  logic [1:0][10:0] beam_position;
  logic [2:0][11:0] vector;

  logic             frame_start1, out_ready1;
  logic             busy1, out_valid1, last_in_row1, last_in_frame1, frame_done1;
  logic [1:0][10:0] beam_position1;
  logic [2:0][11:0] vector1;
`ifdef PIXEL_RAY_SCHEDULER_STALL_COUNT_EN
  logic [15:0]      stall_count, stall_count1;
`endif

  pixel_ray_scheduler #(.H_PIXELS(H), .V_PIXELS(V)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_abort(frame_abort),
    .camera_location(camera_location), .beginning_pixel_location(beginning_pixel_location),
    .pixels_delta_location(pixels_delta_location), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .beam_position(beam_position), .vector(vector),
    .last_in_row(last_in_row), .last_in_frame(last_in_frame),
`ifdef PIXEL_RAY_SCHEDULER_STALL_COUNT_EN
    .stall_count(stall_count),
`endif
    .frame_done(frame_done)
  );

  pixel_ray_scheduler #(.H_PIXELS(1), .V_PIXELS(1)) dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start1), .frame_abort(frame_abort),
    .camera_location(camera_location), .beginning_pixel_location(beginning_pixel_location),
    .pixels_delta_location(pixels_delta_location), .busy(busy1), .out_valid(out_valid1),
    .out_ready(out_ready1), .beam_position(beam_position1), .vector(vector1),
    .last_in_row(last_in_row1), .last_in_frame(last_in_frame1),
`ifdef PIXEL_RAY_SCHEDULER_STALL_COUNT_EN
    .stall_count(stall_count1),
`endif
    .frame_done(frame_done1)
  );

  typedef struct {
    int          x;
    int          y;
    logic [11:0] v0, v1, v2;
    logic        lir, lif;
  } vec_t;

  vec_t        tbl[12];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [11:0] ec[3], eb[3], ed[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int c0, c1, c2, b0, b1, b2, e0, e1, e2);
    camera_location          = {12'(c2), 12'(c1), 12'(c0)};
    beginning_pixel_location = {12'(b2), 12'(b1), 12'(b0)};
    pixels_delta_location    = {12'(e2), 12'(e1), 12'(e0)};
  endtask

  task automatic latch_exp;
    for (int i = 0; i < 3; i++) begin
      ec[i] = camera_location[i];
      eb[i] = beginning_pixel_location[i];
      ed[i] = pixels_delta_location[i];
    end
  endtask

  // Direct per-pixel formula, computed in wide integers and reduced mod 4096
  function automatic logic [35:0] model(input int x, input int y);
    int t0, t1, t2;
    t0 = int'(ec[0]) - int'(eb[0]) - x * int'(ed[0]);
    t1 = int'(ec[1]) - int'(eb[1]) - y * int'(ed[1]);
    t2 = int'(ec[2]) - int'(eb[2]) + x * int'(ed[2]);
    return {t2[11:0], t1[11:0], t0[11:0]};
  endfunction

  task automatic chk_model(input string tag, input int x, input int y);
    logic [35:0] mv;
    mv = model(x, y);
    chk($sformatf("%s(%0d,%0d)", tag, x, y),
        {out_valid, beam_position, vector, last_in_row, last_in_frame},
        {1'b1, 11'(x), 11'(y), mv, 1'(x == H - 1), 1'((x == H - 1) && (y == V - 1))});
  endtask

  task automatic start_frame;
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
  endtask

  task automatic chk_done(input string tag);
    chk(tag, {out_valid, busy, frame_done}, 3'b001);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 12'd90, 12'd180, 12'd270, 1'b0, 1'b0};
    tbl[1]  = '{1, 0, 12'd88, 12'd180, 12'd275, 1'b0, 1'b0};
    tbl[2]  = '{2, 0, 12'd86, 12'd180, 12'd280, 1'b0, 1'b0};
    tbl[3]  = '{3, 0, 12'd84, 12'd180, 12'd285, 1'b1, 1'b0};
    tbl[4]  = '{0, 1, 12'd90, 12'd177, 12'd270, 1'b0, 1'b0};
    tbl[5]  = '{1, 1, 12'd88, 12'd177, 12'd275, 1'b0, 1'b0};
    tbl[6]  = '{2, 1, 12'd86, 12'd177, 12'd280, 1'b0, 1'b0};
    tbl[7]  = '{3, 1, 12'd84, 12'd177, 12'd285, 1'b1, 1'b0};
    tbl[8]  = '{0, 2, 12'd90, 12'd174, 12'd270, 1'b0, 1'b0};
    tbl[9]  = '{1, 2, 12'd88, 12'd174, 12'd275, 1'b0, 1'b0};
    tbl[10] = '{2, 2, 12'd86, 12'd174, 12'd280, 1'b0, 1'b0};
    tbl[11] = '{3, 2, 12'd84, 12'd174, 12'd285, 1'b1, 1'b1};

    rst = 1'b1; frame_start = 1'b0; frame_abort = 1'b0; out_ready = 1'b1;
    frame_start1 = 1'b0; out_ready1 = 1'b1;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step;
    chk("reset", {busy, out_valid, frame_done, last_in_row, last_in_frame, beam_position, vector}, '0);
    chk("reset_1x1", {busy1, out_valid1, frame_done1, last_in_row1, last_in_frame1, beam_position1, vector1}, '0);
    rst = 1'b0;
    step;

    // Main 4x3 scan against the hand-computed table
    set_cfg(100, 200, 300, 10, 20, 30, 2, 3, 5);
    start_frame;
    chk("start_busy", busy, 1'b1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("table[%0d]", i),
          {out_valid, beam_position, vector, last_in_row, last_in_frame},
          {1'b1, 11'(tbl[i].x), 11'(tbl[i].y), tbl[i].v2, tbl[i].v1, tbl[i].v0, tbl[i].lir, tbl[i].lif});
      step;
    end
    chk_done("main_done");

    // Wrap scan, started in the frame_done cycle
    set_cfg(0, 50, 7, 0, 10, 7, 1, 1, 4095);
    latch_exp;
    start_frame;
    chk("wrap_done_cleared", frame_done, 1'b0);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        if (x == 1 && y == 0) chk("wrap_x1_v0_v2", {vector[0], vector[2]}, {12'd4095, 12'd4095});
        chk_model("wrap", x, y);
        step;
      end
    chk_done("wrap_done");
    step;
    chk("done_one_cycle", frame_done, 1'b0);

    // Backpressure at (2,1) for 5 cycles
    set_cfg(100, 200, 300, 10, 20, 30, 2, 3, 5);
    latch_exp;
    start_frame;
    for (int i = 0; i < 12; i++) begin
      chk_model("bp", i % H, i / H);
      if (i == 6) begin
        out_ready = 1'b0;
        repeat (5) begin
          step;
          chk_model("bp_hold", 2, 1);
        end
        out_ready = 1'b1;
      end
      step;
    end
    chk_done("bp_done");
`ifdef PIXEL_RAY_SCHEDULER_STALL_COUNT_EN
    chk("stall_count", stall_count, 16'd5);
`endif

    // Mid-frame frame_start and config change have no effect
    latch_exp;
    start_frame;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) begin
        frame_start = 1'b1;
        set_cfg(7, 7, 7, 1, 1, 1, 9, 9, 9);
      end
      if (i == 5) frame_start = 1'b0;
      chk_model("restart", i % H, i / H);
      step;
    end
    chk_done("restart_done");
    step;
    chk("restart_not_queued", {busy, out_valid}, 2'b00);

    // Abort at (1,1)
    set_cfg(100, 200, 300, 10, 20, 30, 2, 3, 5);
    latch_exp;
    start_frame;
    for (int i = 0; i < 6; i++) begin
      chk_model("pre_abort", i % H, i / H);
      if (i < 5) step;
    end
    frame_abort = 1'b1;
    step;
    frame_abort = 1'b0;
    chk("abort_next", {out_valid, busy, frame_done}, 3'b000);
    step;
    chk("abort_no_done", {out_valid, busy, frame_done}, 3'b000);
    frame_start = 1'b1; frame_abort = 1'b1;
    step;
    frame_start = 1'b0; frame_abort = 1'b0;
    chk("abort_beats_start", {out_valid, busy}, 2'b00);
    set_cfg(1000, 2000, 3000, 1, 2, 3, 7, 11, 13);
    latch_exp;
    start_frame;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        chk_model("after_abort", x, y);
        step;
      end
    chk_done("after_abort_done");

    // Reset during RUN
    start_frame;
    repeat (3) step;
    chk("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rst_in_run", {busy, out_valid, frame_done, last_in_row, last_in_frame, beam_position, vector}, '0);
    step;

    // 1x1 instance
    set_cfg(50, 60, 70, 5, 6, 7, 1, 1, 1);
    frame_start1 = 1'b1;
    step;
    frame_start1 = 1'b0;
    chk("one_item", {out_valid1, busy1, beam_position1, vector1, last_in_row1, last_in_frame1},
        {1'b1, 1'b1, 22'd0, 12'd63, 12'd54, 12'd45, 1'b1, 1'b1});
    step;
    chk("one_done", {out_valid1, busy1, frame_done1}, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
